coprosit_issue_buffer: RTL and testbench

Issue stage of the Coprosit coprocessor, sitting between the core's X-interface issue/commit channels and the posit execution unit.
- Instantiates the Coprosit predecoder to decide acceptance of each offloaded instruction.
- Completes the issue handshake and buffers accepted instructions with their source operands in an in-order queue.
- Releases an entry to the execution unit only after the core commits it; killed entries are dropped.

---
 rtl/coprosit_pkg.sv | 43 ++++
 rtl/coprosit_issue_buffer_if.sv | 41 ++++
 rtl/coprosit_predecoder.sv | 21 ++
 rtl/coprosit_issue_buffer.sv | 84 ++++++++
 tb/tb_coprosit_issue_buffer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/coprosit_pkg.sv
// coprosit_pkg: shared widths, predecoder result and issue-stage record types for Coprosit.
package coprosit_pkg;

    localparam int CP_XLEN     = 32;
    localparam int CP_ID_WIDTH = 4;
    localparam int CP_NUM_RS   = 2;

    localparam logic [6:0] OPC_COPROSIT = 7'b0001011;

    // funct3 classes of the custom-0 posit opcode space
    typedef enum logic [2:0] {
        F3_BINARY = 3'b000,
        F3_UNARY  = 3'b001,
        F3_NOWB   = 3'b010
    } prd_f3_e;

    typedef struct packed {
        logic                 accept;
        logic                 writeback;
        logic [CP_NUM_RS-1:0] use_gprs;
    } prd_t;

    typedef struct packed {
        logic [31:0]                  instr;
        logic [CP_ID_WIDTH-1:0]       id;
        logic [CP_NUM_RS*CP_XLEN-1:0] rs;
        logic [CP_NUM_RS-1:0]         rs_valid;
    } issue_req_t;

    typedef struct packed {
        logic [CP_ID_WIDTH-1:0] id;
        logic                   kill;
    } commit_req_t;

    typedef struct packed {
        logic [31:0]                  instr;
        logic [CP_ID_WIDTH-1:0]       id;
        logic [CP_NUM_RS*CP_XLEN-1:0] rs;
        logic                         committed;
        logic                         killed;
    } issue_entry_t;

endpackage

// File: rtl/coprosit_issue_buffer_if.sv
// coprosit_issue_buffer_if: X-interface issue/commit channels, execution-unit output channel and occupancy.
//   slave  : the issue buffer side
//   master : the core / execution-unit side
interface coprosit_issue_buffer_if #(
    parameter int DEPTH    = 4,
    parameter int XLEN     = 32,
    parameter int ID_WIDTH = 4,
    parameter int NUM_RS   = 2
);
    logic                     issue_valid_i;
    logic                     issue_ready_o;
    logic [31:0]              issue_instr_i;
    logic [ID_WIDTH-1:0]      issue_id_i;
    logic [NUM_RS*XLEN-1:0]   issue_rs_i;
    logic [NUM_RS-1:0]        issue_rs_valid_i;
    logic                     issue_accept_o;
    logic                     issue_writeback_o;
    logic                     commit_valid_i;
    logic [ID_WIDTH-1:0]      commit_id_i;
    logic                     commit_kill_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [31:0]              out_instr_o;
    logic [ID_WIDTH-1:0]      out_id_o;
    logic [NUM_RS*XLEN-1:0]   out_rs_o;
    logic [$clog2(DEPTH):0]   count_o;

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
        input  commit_valid_i, commit_id_i, commit_kill_i, out_ready_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o,
        output out_valid_o, out_instr_o, out_id_o, out_rs_o, count_o
    );

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
        output commit_valid_i, commit_id_i, commit_kill_i, out_ready_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o,
        input  out_valid_o, out_instr_o, out_id_o, out_rs_o, count_o
    );
endinterface

// File: rtl/coprosit_predecoder.sv
// coprosit_predecoder: decides acceptance, GPR writeback and source-operand use of an offloaded instruction.
//   opcode_i : instruction bits [6:0]
//   funct3_i : instruction bits [14:12]
//   prd_o    : accept / writeback / per-operand use flags
module coprosit_predecoder
    import coprosit_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output prd_t       prd_o
);
    logic acc;

    always_comb begin
        acc = opcode_i == OPC_COPROSIT &&
              (funct3_i == F3_BINARY || funct3_i == F3_UNARY || funct3_i == F3_NOWB);
        prd_o.accept    = acc;
        prd_o.writeback = acc && funct3_i != F3_NOWB;
        prd_o.use_gprs  = !acc ? '0 : funct3_i == F3_UNARY ? CP_NUM_RS'(1) : '1;
    end
endmodule

// File: rtl/coprosit_issue_buffer.sv
// coprosit_issue_buffer: accepts offloaded posit instructions and releases them in order once committed.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : issue handshake, commit messages, head output to the execution unit, occupancy
// Entry widths come from coprosit_pkg; XLEN/ID_WIDTH/NUM_RS must match the package constants.
module coprosit_issue_buffer
    import coprosit_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int XLEN     = CP_XLEN,
    parameter int ID_WIDTH = CP_ID_WIDTH,
    parameter int NUM_RS   = CP_NUM_RS
) (
    input  logic clk_i,
    input  logic rst_i,
    coprosit_issue_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    prd_t         prd;
    issue_req_t   req;
    commit_req_t  cmt;
    issue_entry_t ent_q [DEPTH];
    issue_entry_t head;
    logic [DEPTH-1:0] vld_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic full, rs_ok, push, pop, drop;

    assign req = '{instr: bus.issue_instr_i, id: bus.issue_id_i, rs: bus.issue_rs_i, rs_valid: bus.issue_rs_valid_i};
    assign cmt = '{id: bus.commit_id_i, kill: bus.commit_kill_i};

    coprosit_predecoder u_prd (
        .opcode_i (req.instr[6:0]),
        .funct3_i (req.instr[14:12]),
        .prd_o    (prd)
    );

    // Ready never looks at a same-cycle pop so out_ready_i has no path to issue_ready_o.
    always_comb begin
        head              = ent_q[rd_ptr_q];
        full              = count_q == CW'(DEPTH);
        rs_ok             = &(~prd.use_gprs | req.rs_valid);
        bus.issue_ready_o = !prd.accept || (!full && rs_ok);
        push              = bus.issue_valid_i && bus.issue_ready_o && prd.accept;
        bus.out_valid_o   = vld_q[rd_ptr_q] && head.committed && !head.killed;
        drop              = vld_q[rd_ptr_q] && head.committed && head.killed;
        pop               = (bus.out_valid_o && bus.out_ready_i) || drop;
    end

    assign bus.issue_accept_o    = prd.accept;
    assign bus.issue_writeback_o = prd.writeback;
    assign bus.out_instr_o       = head.instr;
    assign bus.out_id_o          = head.id;
    assign bus.out_rs_o          = head.rs;
    assign bus.count_o           = count_q;

    // Push and pop never target the same slot: the push slot is empty, the pop slot is occupied.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pop) vld_q[rd_ptr_q] <= 1'b0;
            if (push) vld_q[wr_ptr_q] <= 1'b1;
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            wr_ptr_q <= wr_ptr_q + AW'(push);
            count_q  <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Payload and flags need no reset: an entry is only looked at while its vld_q bit is set,
    // and the slot being pushed is never valid, so a same-cycle commit for it is ignored.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++)
            if (bus.commit_valid_i && vld_q[i] && !ent_q[i].committed && ent_q[i].id == cmt.id) begin
                ent_q[i].committed <= 1'b1;
                ent_q[i].killed    <= cmt.kill;
            end
        if (push) ent_q[wr_ptr_q] <= '{instr: req.instr, id: req.id, rs: req.rs, committed: 1'b0, killed: 1'b0};
    end
endmodule

// File: tb/tb_coprosit_issue_buffer.sv
// tb_coprosit_issue_buffer: directed self-checking bench for the Coprosit issue buffer.
module tb_coprosit_issue_buffer;
    localparam logic [31:0] ADD  = 32'h0020808B;
    localparam logic [31:0] UNA  = 32'h0000908B;
    localparam logic [31:0] STO  = 32'h0020A00B;
    localparam logic [31:0] ADDI = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int failed = 0;

    coprosit_issue_buffer_if bus ();

    coprosit_issue_buffer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rs_of(input logic [3:0] id);
        return {28'hB000000, id, 28'hA000000, id};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [3:0] id, input logic [1:0] rsv);
        bus.issue_valid_i    = 1'b1;
        bus.issue_instr_i    = instr;
        bus.issue_id_i       = id;
        bus.issue_rs_i       = rs_of(id);
        bus.issue_rs_valid_i = rsv;
        #1;
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        bus.commit_valid_i = 1'b1;
        bus.commit_id_i    = id;
        bus.commit_kill_i  = kill;
        #1;
    endtask

    // A commit aimed at the instruction being pushed in the same cycle is a core protocol error.
    always @(posedge clk) begin
        if (!rst && bus.issue_valid_i && bus.issue_ready_o && bus.issue_accept_o &&
            bus.commit_valid_i && bus.commit_id_i == bus.issue_id_i) begin
            failed++;
            $error("FAIL protocol_commit_on_push id=%0h", bus.commit_id_i);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.issue_valid_i    = 1'b0;
        bus.issue_instr_i    = '0;
        bus.issue_id_i       = '0;
        bus.issue_rs_i       = '0;
        bus.issue_rs_valid_i = '0;
        bus.commit_valid_i   = 1'b0;
        bus.commit_id_i      = '0;
        bus.commit_kill_i    = 1'b0;
        bus.out_ready_i      = 1'b0;
        cyc(2);
        chk("rst_count", 64'(bus.count_o), 0);
        chk("rst_out_valid", 64'(bus.out_valid_o), 0);
        rst = 1'b0;
        cyc();

        // accepted posit add, committed, popped
        bus.out_ready_i = 1'b1;
        offer(ADD, 4'd3, 2'b11);
        chk("add_accept", 64'(bus.issue_accept_o), 1);
        chk("add_ready", 64'(bus.issue_ready_o), 1);
        chk("add_wb", 64'(bus.issue_writeback_o), 1);
        cyc();
        bus.issue_valid_i = 1'b0;
        chk("add_count1", 64'(bus.count_o), 1);
        chk("add_uncommitted", 64'(bus.out_valid_o), 0);
        commit(4'd3, 1'b0);
        chk("add_commit_same_cycle", 64'(bus.out_valid_o), 0);
        cyc();
        bus.commit_valid_i = 1'b0;
        chk("add_out_valid", 64'(bus.out_valid_o), 1);
        chk("add_out_id", 64'(bus.out_id_o), 3);
        chk("add_out_instr", 64'(bus.out_instr_o), 64'(ADD));
        chk("add_out_rs", bus.out_rs_o, rs_of(4'd3));
        cyc();
        chk("add_count0", 64'(bus.count_o), 0);
        chk("add_popped", 64'(bus.out_valid_o), 0);

        // non-coprocessor instruction is rejected
        offer(ADDI, 4'd7, 2'b00);
        chk("addi_ready", 64'(bus.issue_ready_o), 1);
        chk("addi_accept", 64'(bus.issue_accept_o), 0);
        chk("addi_wb", 64'(bus.issue_writeback_o), 0);
        cyc();
        bus.issue_valid_i = 1'b0;
        chk("addi_count", 64'(bus.count_o), 0);
        commit(4'd7, 1'b0);
        cyc();
        bus.commit_valid_i = 1'b0;
        chk("addi_commit_count", 64'(bus.count_o), 0);
        chk("addi_commit_valid", 64'(bus.out_valid_o), 0);

        // operand readiness
        offer(ADD, 4'd1, 2'b01);
        chk("add_rs2_missing", 64'(bus.issue_ready_o), 0);
        offer(UNA, 4'd1, 2'b00);
        for (int i = 0; i < 3; i++) begin
            chk("una_wait", 64'(bus.issue_ready_o), 0);
            cyc();
        end
        chk("una_wait_count", 64'(bus.count_o), 0);
        bus.issue_rs_valid_i = 2'b01;
        #1;
        chk("una_rs1_ready", 64'(bus.issue_ready_o), 1);
        cyc();
        bus.issue_valid_i = 1'b0;
        chk("una_count", 64'(bus.count_o), 1);
        commit(4'd1, 1'b0);
        cyc();
        bus.commit_valid_i = 1'b0;
        chk("una_out_id", 64'(bus.out_id_o), 1);
        chk("una_out_instr", 64'(bus.out_instr_o), 64'(UNA));
        cyc();
        chk("una_count0", 64'(bus.count_o), 0);

        // fill, full backpressure, no pop-through
        bus.out_ready_i = 1'b0;
        offer(ADD, 4'd0, 2'b11);
        cyc();
        offer(ADD, 4'd1, 2'b11);
        cyc();
        offer(STO, 4'd2, 2'b11);
        chk("sto_accept", 64'(bus.issue_accept_o), 1);
        chk("sto_wb", 64'(bus.issue_writeback_o), 0);
        cyc();
        offer(ADD, 4'd3, 2'b11);
        cyc();
        offer(ADD, 4'd4, 2'b11);
        chk("full_count", 64'(bus.count_o), 4);
        chk("full_ready", 64'(bus.issue_ready_o), 0);
        commit(4'd0, 1'b0);
        cyc();
        bus.commit_valid_i = 1'b0;
        chk("full_head_valid", 64'(bus.out_valid_o), 1);
        chk("full_head_id", 64'(bus.out_id_o), 0);
        bus.out_ready_i = 1'b1;
        #1;
        chk("no_pop_through", 64'(bus.issue_ready_o), 0);
        cyc();
        bus.out_ready_i = 1'b0;
        chk("after_pop_count", 64'(bus.count_o), 3);
        chk("after_pop_ready", 64'(bus.issue_ready_o), 1);
        cyc();
        bus.issue_valid_i = 1'b0;
        chk("refill_count", 64'(bus.count_o), 4);
        commit(4'd1, 1'b1);
        cyc();
        chk("kill_no_valid", 64'(bus.out_valid_o), 0);
        commit(4'd2, 1'b1);
        cyc();
        commit(4'd3, 1'b1);
        cyc();
        commit(4'd4, 1'b1);
        cyc();
        bus.commit_valid_i = 1'b0;
        cyc(3);
        chk("drain_count", 64'(bus.count_o), 0);
        chk("drain_valid", 64'(bus.out_valid_o), 0);

        // out-of-order commit, killed head dropped
        bus.out_ready_i = 1'b1;
        offer(ADD, 4'd5, 2'b11);
        cyc();
        offer(ADD, 4'd6, 2'b11);
        cyc();
        bus.issue_valid_i = 1'b0;
        commit(4'd6, 1'b0);
        cyc();
        bus.commit_valid_i = 1'b0;
        chk("ooo_blocked", 64'(bus.out_valid_o), 0);
        chk("ooo_count2", 64'(bus.count_o), 2);
        commit(4'd5, 1'b1);
        cyc();
        bus.commit_valid_i = 1'b0;
        chk("killed_head_hidden", 64'(bus.out_valid_o), 0);
        chk("killed_head_count", 64'(bus.count_o), 2);
        cyc();
        chk("drop_count", 64'(bus.count_o), 1);
        chk("next_valid", 64'(bus.out_valid_o), 1);
        chk("next_id", 64'(bus.out_id_o), 6);
        cyc();
        chk("ooo_count0", 64'(bus.count_o), 0);

        // asynchronous reset with committed entries
        bus.out_ready_i = 1'b0;
        offer(ADD, 4'd8, 2'b11);
        cyc();
        offer(ADD, 4'd9, 2'b11);
        cyc();
        bus.issue_valid_i = 1'b0;
        commit(4'd8, 1'b0);
        cyc();
        commit(4'd9, 1'b0);
        cyc();
        bus.commit_valid_i = 1'b0;
        chk("pre_rst_valid", 64'(bus.out_valid_o), 1);
        chk("pre_rst_count", 64'(bus.count_o), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(bus.out_valid_o), 0);
        chk("async_rst_count", 64'(bus.count_o), 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_valid", 64'(bus.out_valid_o), 0);
        chk("post_rst_count", 64'(bus.count_o), 0);
        chk("post_rst_ready", 64'(bus.issue_ready_o), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
